// File: rtl/register_file_if.sv
// Register file access bundle: one write port and two read ports.
// The datapath side is the master; the register file is the slave.
interface register_file_if #(
    parameter int N    = 32,
    parameter int ADDR = 5
);
    logic            RegWrite;
    logic [ADDR-1:0] WriteRegister;
    logic [N-1:0]    WriteData;
    logic [ADDR-1:0] ReadRegister1;
    logic [ADDR-1:0] ReadRegister2;
    logic [N-1:0]    ReadData1;
    logic [N-1:0]    ReadData2;

    modport master (
        output RegWrite,
        output WriteRegister,
        output WriteData,
        output ReadRegister1,
        output ReadRegister2,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  RegWrite,
        input  WriteRegister,
        input  WriteData,
        input  ReadRegister1,
        input  ReadRegister2,
        output ReadData1,
        output ReadData2
    );
endinterface

// File: rtl/register_file.sv
// MIPS 32x32 register file: r0 hardwired to zero, $gp/$sp preset on reset.
// Two combinational read ports with write-through bypass, one write port.
module register_file #(
    parameter int          N        = 32,
    parameter int          ADDR     = 5,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
    input logic            clk,
    input logic            reset,
    register_file_if.slave rf
);
    localparam int NREG = 1 << ADDR;

    logic [N-1:0] regs [1:NREG-1];
    logic         wr_en;
    logic         hit1;
    logic         hit2;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;

    assign wr_en = rf.RegWrite && (rf.WriteRegister != '0);
    assign hit1  = wr_en && (rf.WriteRegister == rf.ReadRegister1);
    assign hit2  = wr_en && (rf.WriteRegister == rf.ReadRegister2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++) begin
                if (i == 28)
                    regs[i] <= N'(GP_RESET);
                else if (i == 29)
                    regs[i] <= N'(SP_RESET);
                else
                    regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rf.WriteRegister] <= rf.WriteData;
        end
    end

    // Index 0 has no storage; the bypass wins over the array
    always_comb begin
        rd1 = '0;
        if (rf.ReadRegister1 != '0) begin
            if (hit1)
                rd1 = rf.WriteData;
            else
                rd1 = regs[rf.ReadRegister1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rf.ReadRegister2 != '0) begin
            if (hit2)
                rd2 = rf.WriteData;
            else
                rd2 = regs[rf.ReadRegister2];
        end
    end

    assign rf.ReadData1 = rd1;
    assign rf.ReadData2 = rd2;
endmodule
